barrel_projection_wrapper: RTL and testbench
============================================

BARREL_PROJECTION_WRAPPER -- requirements
Module: barrel_projection_wrapper

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter WIDTH, default 1080, SHALL set the horizontal raster size; the x count runs 0..WIDTH inclusive.
REQ-003 Parameter HEIGHT, default 960, SHALL set the vertical raster size; the y count runs 0..HEIGHT inclusive.
REQ-004 Parameter K, default 1, SHALL set the distortion coefficient numerator.
REQ-005 Parameter K_SHIFT, default 10, SHALL set the distortion coefficient right-shift.
REQ-006 The ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- AXIS_IN_tdata  in  16  pixel data; accepted but not used by the address path
- AXIS_IN_tvalid  in  1  input beat valid
- AXIS_IN_tready  out  1  input ready
- AXIS_In_tuser  in  1  start-of-frame marker on the beat
- addr_vld  out  1  xOut/yOut valid strobe
- xOut  out  12  source x address, unsigned
- yOut  out  12  source y address, unsigned

Function
REQ-007 AXIS_IN_tready SHALL be 0 while reset is high and 1 in every other cycle; a beat is accepted when tvalid and tready are both 1.
REQ-008 A raster counter (X, Y) SHALL advance once per accepted beat:
- X wraps from WIDTH to 0.
- Y increments when X wraps, and wraps from HEIGHT to 0.
- Cycles with no accepted beat hold the counter.
REQ-009 An accepted beat with AXIS_In_tuser=1 SHALL be mapped as pixel (0,0), and the counter SHALL then move to (1,0).
REQ-010 Each accepted beat's (X,Y) SHALL be mapped as follows:
- CX=WIDTH/2 and CY=HEIGHT/2, using integer division.
- dx=X-CX and dy=Y-CY, both signed 13-bit.
- r2=dx*dx+dy*dy, unsigned 21-bit.
- s=4096+((r2*K)>>K_SHIFT), a Q12 scale.
- xs=CX+((dx*s)>>>12) and ys=CY+((dy*s)>>>12), where >>> is an arithmetic (floor) shift and full precision is kept.
REQ-011 The mapping SHALL be a 4-stage pipeline:
- Stage 1: dx, dy.
- Stage 2: r2.
- Stage 3: s and the products.
- Stage 4: shift, add, final output register.
REQ-012 addr_vld SHALL pulse exactly 4 cycles after the accepting edge, with xOut/yOut holding that beat's result in the same cycle.
REQ-013 The pipeline SHALL be fully pipelined: back-to-back accepted beats produce back-to-back addr_vld pulses with no bubbles and no reordering.
REQ-014 When addr_vld is 0, xOut/yOut SHALL hold their last valid values.

Reset
REQ-015 While reset is high:
- X, Y, all pipeline valid bits, addr_vld, xOut and yOut SHALL be cleared to 0 at each rising clock edge.
- No beat is accepted.
REQ-016 Asserting reset mid-frame SHALL discard all in-flight results, so addr_vld=0 from the first edge with reset=1.
REQ-017 After reset deasserts, the first accepted beat SHALL be pixel (0,0).

Configuration
REQ-018 When macro BARREL_CLAMP_EN is defined, xs SHALL be clamped to [0, WIDTH-1] and ys to [0, HEIGHT-1] before output.
REQ-019 When BARREL_CLAMP_EN is not defined, xOut/yOut SHALL be the low 12 bits of the two's-complement xs/ys, with no clamping.

Verification
REQ-020 Reset for 100 ns, then hold tvalid=1 continuously, tuser=0, with default parameters. The required response is:
- tready=1 from the first post-reset edge.
- First addr_vld 4 cycles after the first accept.
- addr_vld then high every cycle.
- Exactly WIDTH+1=1081 pulses per output line.
REQ-021 Pixel (540,480) -> xOut=540, yOut=480. Pixel (640,480) -> xOut=640, yOut=480.
REQ-022 Pixel (0,0) -> clamp build: xOut=0, yOut=0. Unclamped build: xOut=4028, yOut=4036.
REQ-023 Pixel (1080,0) -> clamp build: xOut=1079, yOut=0. Unclamped build: xOut=1147, yOut=4036.
REQ-024 tuser=1 injected on the beat accepted at counter (37,5) -> that beat emerges as pixel (0,0) results, and the next beat is mapped as (1,0).
REQ-025 Toggle tvalid 1-0-1 and assert reset for 1 cycle mid-line. The required response is:
- addr_vld pulses only for accepted beats, each exactly 4 cycles later.
- After the reset, no stale pulses.
- The first new pulse carries the (0,0) mapping.

Source files
------------

// File: rtl/barrel_projection_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : barrel_projection_wrapper
//  Purpose  : Raster-scan address generator for barrel-distortion correction.
//             A pixel counter (X, Y) advances on every accepted AXI-Stream
//             beat. Each beat's coordinates pass through a five-register
//             pipeline: an input capture register, then four mapping stages.
//             The result is the source (x, y) fetch address, which is
//             presented on xOut/yOut with the addr_vld strobe.
//  Options  : BARREL_CLAMP_EN - when defined, the source address is clamped
//             to the visible raster. When undefined, the low 12 bits of the
//             two's-complement result are passed through unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module barrel_projection_wrapper #(
  parameter int WIDTH   = 1080,
  parameter int HEIGHT  = 960,
  parameter int K       = 1,
  parameter int K_SHIFT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AXIS_IN_tdata,
  input  logic        AXIS_IN_tvalid,
  output logic        AXIS_IN_tready,
  input  logic        AXIS_In_tuser,
  output logic        addr_vld,
  output logic [11:0] xOut,
  output logic [11:0] yOut
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CX     = WIDTH / 2;
  localparam int CY     = HEIGHT / 2;
  // r2 is 21 bits and K is a 32-bit parameter, so r2*K needs 53 bits.
  localparam int R2K_W  = 21 + 32;
  localparam int S_W    = R2K_W + 1;
  // A signed 13-bit delta times a non-negative (S_W+1)-bit signed scale.
  localparam int PROD_W = 13 + S_W + 1;

  localparam logic [11:0]              X_LAST = 12'(WIDTH);
  localparam logic [11:0]              Y_LAST = 12'(HEIGHT);
  localparam logic signed [12:0]       CX_S   = 13'(CX);
  localparam logic signed [12:0]       CY_S   = 13'(CY);
  localparam logic signed [PROD_W-1:0] CX_P   = PROD_W'(CX);
  localparam logic signed [PROD_W-1:0] CY_P   = PROD_W'(CY);
`ifdef BARREL_CLAMP_EN
  localparam logic signed [PROD_W-1:0] XMAX_P = PROD_W'(WIDTH - 1);
  localparam logic signed [PROD_W-1:0] YMAX_P = PROD_W'(HEIGHT - 1);
`endif

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                     accept;

  // Raster counter and the coordinates assigned to the current beat
  logic [11:0]              x_q, y_q;
  logic [11:0]              x_d, y_d;
  logic [11:0]              pix_x, pix_y;

  // Input capture register
  logic                     v0_q;
  logic [11:0]              px0_q, py0_q;

  // Stage 1: centred deltas
  logic                     v1_q;
  logic signed [12:0]       dx1_d, dy1_d;
  logic signed [12:0]       dx1_q, dy1_q;

  // Stage 2: squared radius
  logic                     v2_q;
  logic signed [20:0]       dx_ext, dy_ext;
  logic [20:0]              r2_d, r2_q;
  logic signed [12:0]       dx2_q, dy2_q;

  // Stage 3: scale factor and scaled deltas
  logic                     v3_q;
  logic [R2K_W-1:0]         r2k;
  logic [S_W-1:0]           s_d;
  logic signed [PROD_W-1:0] prodx_d, prody_d;
  logic signed [PROD_W-1:0] prodx_q, prody_q;

  // Stage 4: re-centred source address
  logic signed [PROD_W-1:0] xs, ys;
  logic [11:0]              xo_d, yo_d;

  // Pixel data is carried alongside the stream but is not used for addressing.
  logic                     unused_tdata;
  assign unused_tdata = ^AXIS_IN_tdata;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The block is always ready, except while it is held in reset.
  assign AXIS_IN_tready = ~reset;
  assign accept         = AXIS_IN_tvalid & ~reset;

  // Pick the current beat's pixel (start of frame forces 0,0) and the next count
  always_comb begin
    pix_x = AXIS_In_tuser ? 12'd0 : x_q;
    pix_y = AXIS_In_tuser ? 12'd0 : y_q;
    x_d   = pix_x + 12'd1;
    y_d   = pix_y;
    if (pix_x == X_LAST) begin
      x_d = 12'd0;
      y_d = (pix_y == Y_LAST) ? 12'd0 : pix_y + 12'd1;
    end
  end

  // Raster counter plus capture of the accepted beat's coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= 12'd0;
      y_q   <= 12'd0;
      v0_q  <= 1'b0;
      px0_q <= 12'd0;
      py0_q <= 12'd0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        x_q   <= x_d;
        y_q   <= y_d;
        px0_q <= pix_x;
        py0_q <= pix_y;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: offsets from the optical centre
  // --------------------------------------------------------------------------
  // Form the signed offsets of the captured pixel from the optical centre
  always_comb begin
    dx1_d = $signed({1'b0, px0_q}) - CX_S;
    dy1_d = $signed({1'b0, py0_q}) - CY_S;
  end

  // Register the offsets
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      dx1_q <= 13'sd0;
      dy1_q <= 13'sd0;
    end else begin
      v1_q  <= v0_q;
      dx1_q <= dx1_d;
      dy1_q <= dy1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: squared radius
  // --------------------------------------------------------------------------
  // Square and sum the offsets; the widening keeps the products exact
  always_comb begin
    dx_ext = 21'(dx1_q);
    dy_ext = 21'(dy1_q);
    r2_d   = $unsigned(dx_ext * dx_ext + dy_ext * dy_ext);
  end

  // Register r2; the offsets travel along for the next stage
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q  <= 1'b0;
      r2_q  <= 21'd0;
      dx2_q <= 13'sd0;
      dy2_q <= 13'sd0;
    end else begin
      v2_q  <= v1_q;
      r2_q  <= r2_d;
      dx2_q <= dx1_q;
      dy2_q <= dy1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: Q12 scale and scaled offsets
  // --------------------------------------------------------------------------
  // Compute s = 1.0 + r2*K/2^K_SHIFT in Q12, then multiply both offsets by s
  always_comb begin
    r2k     = R2K_W'(r2_q) * R2K_W'(K);
    s_d     = S_W'(4096) + S_W'(r2k >> K_SHIFT);
    prodx_d = PROD_W'(dx2_q) * PROD_W'($signed({1'b0, s_d}));
    prody_d = PROD_W'(dy2_q) * PROD_W'($signed({1'b0, s_d}));
  end

  // Register the full-precision products
  always_ff @(posedge clk) begin
    if (reset) begin
      v3_q    <= 1'b0;
      prodx_q <= '0;
      prody_q <= '0;
    end else begin
      v3_q    <= v2_q;
      prodx_q <= prodx_d;
      prody_q <= prody_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 4: floor shift, re-centre, optional clamp
  // --------------------------------------------------------------------------
  // Drop the Q12 fraction with an arithmetic (floor) shift and add the centre back
  always_comb begin
    xs = CX_P + (prodx_q >>> 12);
    ys = CY_P + (prody_q >>> 12);
`ifdef BARREL_CLAMP_EN
    if (xs[PROD_W-1])    xo_d = 12'd0;
    else if (xs > XMAX_P) xo_d = 12'(WIDTH - 1);
    else                 xo_d = xs[11:0];
    if (ys[PROD_W-1])    yo_d = 12'd0;
    else if (ys > YMAX_P) yo_d = 12'(HEIGHT - 1);
    else                 yo_d = ys[11:0];
`else
    xo_d = xs[11:0];
    yo_d = ys[11:0];
`endif
  end

`ifndef BARREL_CLAMP_EN
  // Without clamping, only the low 12 bits reach the outputs.
  logic unused_hi;
  assign unused_hi = ^{xs[PROD_W-1:12], ys[PROD_W-1:12]};
`endif

  // Output register: the address updates only on valid results, otherwise it holds
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_vld <= 1'b0;
      xOut     <= 12'd0;
      yOut     <= 12'd0;
    end else begin
      addr_vld <= v3_q;
      if (v3_q) begin
        xOut <= xo_d;
        yOut <= yo_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barrel_projection_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_barrel_projection_wrapper
//  Purpose  : Self-checking bench for barrel_projection_wrapper with default
//             parameters. Includes a behavioural raster/mapping reference
//             model and randomized valid/start-of-frame/reset stimulus.
//             Define BARREL_CLAMP_EN here as well to check the clamp build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_projection_wrapper;

  localparam int W   = 1080;
  localparam int H   = 960;
  localparam int KC  = 1;
  localparam int KS  = 10;
  localparam int LAT = 4;

`ifdef BARREL_CLAMP_EN
  localparam int X00 = 0;    localparam int Y00 = 0;
  localparam int XE0 = 1079; localparam int YE0 = 0;
`else
  localparam int X00 = 4028; localparam int Y00 = 4036;
  localparam int XE0 = 1147; localparam int YE0 = 4036;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tdata = 16'd0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tready;
  logic        addr_vld;
  logic [11:0] xOut, yOut;

  always #5 clk = ~clk;

  barrel_projection_wrapper dut (
    .clk           (clk),
    .reset         (reset),
    .AXIS_IN_tdata (tdata),
    .AXIS_IN_tvalid(tvalid),
    .AXIS_IN_tready(tready),
    .AXIS_In_tuser (tuser),
    .addr_vld      (addr_vld),
    .xOut          (xOut),
    .yOut          (yOut)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: raster position and in-flight beats by age
  int mx = 0, my = 0;
  bit dl_v [LAT];
  int dl_x [LAT];
  int dl_y [LAT];
  int exp_x = 0, exp_y = 0;
  bit exp_v = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Source address of a pixel, straight from the mapping formulae
  function automatic void map_pixel(input int X, input int Y, output int xo, output int yo);
    longint dx, dy, r2, s, xsv, ysv;
    dx  = X - W / 2;
    dy  = Y - H / 2;
    r2  = dx * dx + dy * dy;
    s   = 4096 + (r2 * KC) / (longint'(1) << KS);
    xsv = W / 2 + floor_div(dx * s, 4096);
    ysv = H / 2 + floor_div(dy * s, 4096);
`ifdef BARREL_CLAMP_EN
    if (xsv < 0) xsv = 0; else if (xsv > W - 1) xsv = W - 1;
    if (ysv < 0) ysv = 0; else if (ysv > H - 1) ysv = H - 1;
`endif
    xo = int'(xsv & 64'hFFF);
    yo = int'(ysv & 64'hFFF);
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, check after it
  task automatic step(input bit v, input bit u, input bit r);
    bit acc, ov;
    int ox, oy, px, py;
    tvalid = v;
    tuser  = u;
    reset  = r;
    tdata  = 16'($urandom);
    #1;
    check_val("tready", 32'(tready), 32'(!r));
    @(posedge clk);
    acc = v && !r;
    ov  = dl_v[LAT-1];
    ox  = dl_x[LAT-1];
    oy  = dl_y[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_x[i] = dl_x[i-1];
      dl_y[i] = dl_y[i-1];
    end
    dl_v[0] = 1'b0;
    if (acc) begin
      px = u ? 0 : mx;
      py = u ? 0 : my;
      dl_v[0] = 1'b1;
      dl_x[0] = px;
      dl_y[0] = py;
      mx = px + 1;
      my = py;
      if (mx > W) begin
        mx = 0;
        my = py + 1;
        if (my > H) my = 0;
      end
    end
    if (r) begin
      mx = 0;
      my = 0;
      for (int i = 0; i < LAT; i++) dl_v[i] = 1'b0;
      ov    = 1'b0;
      exp_x = 0;
      exp_y = 0;
    end
    exp_v = ov;
    if (ov) map_pixel(ox, oy, exp_x, exp_y);
    #1;
    check_val("addr_vld", 32'(addr_vld), 32'(exp_v));
    check_val("xOut", 32'(xOut), 32'(exp_x));
    check_val("yOut", 32'(yOut), 32'(exp_y));
    if (ov && ox == 0 && oy == 0) begin
      check_val("pix0_0_x", 32'(xOut), 32'(X00));
      check_val("pix0_0_y", 32'(yOut), 32'(Y00));
    end
    if (ov && ox == W && oy == 0) begin
      check_val("pixW_0_x", 32'(xOut), 32'(XE0));
      check_val("pixW_0_y", 32'(yOut), 32'(YE0));
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < LAT; i++) begin
      dl_v[i] = 1'b0; dl_x[i] = 0; dl_y[i] = 0;
    end

    // Reset for 100 ns with tvalid already high: nothing may be accepted
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);

    // Continuous stream up to the beat at counter (37,5)
    guard = 0;
    while (!(mx == 37 && my == 5) && guard < 20000) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_val("reach_37_5", 32'(guard < 20000), 32'd1);

    // Start-of-frame on that beat restarts the raster at (0,0)
    step(1'b1, 1'b1, 1'b0);
    check_val("sof_next_x", 32'(mx), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

    // tvalid 1-0-1 then a single reset cycle mid-line
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

    // Randomized valid gaps, rare start-of-frame, one reset mid-run
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, i == 1500);

    // Drain the pipeline
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
